// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one iterative divider between two requesters.
// Define DIV_ZERO_CHECK_EN to answer zero divisors locally with all-ones and rsp_err.
module div_arbiter #(
  parameter int DATA_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] op1_0,
  input  logic [DATA_WIDTH-1:0] op2_0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] op1_1,
  input  logic [DATA_WIDTH-1:0] op2_1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rsp_valid0,
  output logic                  rsp_valid1,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  div_start,
  output logic [DATA_WIDTH-1:0] div_op1,
  output logic [DATA_WIDTH-1:0] div_op2,
  input  logic [DATA_WIDTH-1:0] div_result,
  input  logic                  div_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, prio_q, prio_d, err_q, err_d, win, zero;
  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
`ifdef DIV_ZERO_CHECK_EN
  assign zero = op2_q == '0;
`else
  assign zero = 1'b0;
`endif
  // prio_q high means requester 1 wins a tie
  assign win = (req0 && req1) ? prio_q : req1;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    err_d   = err_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (req0 || req1) begin
        owner_d = win;
        op1_d   = win ? op1_1 : op1_0;
        op2_d   = win ? op2_1 : op2_0;
        err_d   = 1'b0;
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = zero ? RESP : WAIT;
        res_d   = zero ? '1 : res_q;
        err_d   = zero;
      end
      WAIT: if (div_done) begin
        res_d   = div_result;
        state_d = RESP;
      end
      default: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
    end
  end
  assign gnt0       = state_q == ISSUE && !owner_q;
  assign gnt1       = state_q == ISSUE && owner_q;
  assign div_start  = state_q == ISSUE && !zero;
  assign rsp_valid0 = state_q == RESP && !owner_q;
  assign rsp_valid1 = state_q == RESP && owner_q;
  assign rsp_err    = state_q == RESP && err_q;
  assign busy       = state_q != IDLE;
  assign rsp_result = res_q;
  assign div_op1    = op1_q;
  assign div_op2    = op2_q;
endmodule
